// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register bank.
//   - fun_sel operation codes applied to every selected register.
//   - Read-index helpers for the T-first, then-R output mapping:
//       index 0 .. NT-1        -> T1 .. T_NT
//       index NT .. NT+NR-1    -> R1 .. R_NR
package regfile_pkg;

  localparam logic [2:0] FUN_CLR  = 3'b000;
  localparam logic [2:0] FUN_LD   = 3'b001;
  localparam logic [2:0] FUN_DEC  = 3'b010;
  localparam logic [2:0] FUN_INC  = 3'b011;
  localparam logic [2:0] FUN_SHL  = 3'b100;
  localparam logic [2:0] FUN_SHR  = 3'b101;
  localparam logic [2:0] FUN_ROL  = 3'b110;
  localparam logic [2:0] FUN_HOLD = 3'b111;

  // Temporaries occupy the low read indices, so T(k+1) sits at slot k.
  localparam int T_BASE = 0;

  function automatic int t_slot(input int k);
    return T_BASE + k;
  endfunction

  // General registers follow the temporaries: R(k+1) sits at slot nt+k.
  function automatic int r_slot(input int nt, input int k);
    return T_BASE + nt + k;
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// One W-bit register of the bank.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : this register is selected for the current operation
//   fun_sel    : operation code (see regfile_pkg)
//   i_data     : load data
//   q          : current register value
//   d_next     : value the register takes at the next rising edge
//   wrap_hit   : selected inc from all-ones or selected dec from zero
module regfile_cell
  import regfile_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [2:0]   fun_sel,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] q,
  output logic [W-1:0] d_next,
  output logic         wrap_hit
);

  // NOTE: every output of a combinational block gets a default before the
  // case, otherwise unlisted paths hold their value and a latch is inferred.
  always_comb begin
    d_next   = q;
    wrap_hit = 1'b0;
    if (!rst_n) begin
      d_next = '0;
    end else if (en) begin
      case (fun_sel)
        FUN_CLR: d_next = '0;
        FUN_LD:  d_next = i_data;
        FUN_DEC: begin
          d_next   = q - W'(1);
          wrap_hit = (q == '0);
        end
        FUN_INC: begin
          d_next   = q + W'(1);
          wrap_hit = &q;
        end
        FUN_SHL: d_next = q << 1;
        FUN_SHR: d_next = q >> 1;
        // Written with shifts so it also holds for W=1.
        FUN_ROL: d_next = (q << 1) | (q >> (W - 1));
        default: d_next = q;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the block order.
  // The bank is a handful of flops, not a RAM, so each one is reset.
  always_ff @(posedge clk) begin
    q <= d_next;
  end

endmodule

// File: rtl/param_regfile.sv
// Parametrised datapath register bank: NR general registers R1..R_NR and
// NT temporaries T1..T_NT, all W bits, with two registered read ports.
//   clk, rst_n     : clock, synchronous active-low reset
//   i_data         : load data
//   fun_sel        : operation applied to every selected register
//   r_sel, t_sel   : register enables, MSB selects R1 / T1
//   o1_sel, o2_sel : read indices (T first, then R; out of range reads 0)
//   o1, o2         : registered read data (pre-update, or post-update when
//                    BYPASS=1)
//   wrap           : registered; some selected register wrapped last edge
module param_regfile
  import regfile_pkg::*;
#(
  parameter int W      = 8,
  parameter int NR     = 4,
  parameter int NT     = 4,
  parameter int BYPASS = 0,
  parameter int SW     = (NR + NT > 1) ? $clog2(NR + NT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  i_data,
  input  logic [2:0]    fun_sel,
  input  logic [NR-1:0] r_sel,
  input  logic [NT-1:0] t_sel,
  input  logic [SW-1:0] o1_sel,
  input  logic [SW-1:0] o2_sel,
  output logic [W-1:0]  o1,
  output logic [W-1:0]  o2,
  output logic          wrap
);

  localparam int N = NR + NT;

  logic [N-1:0] en;
  logic [N-1:0] wrap_hit;
  logic [W-1:0] q      [N];
  logic [W-1:0] d_next [N];
  logic [W-1:0] rd1;
  logic [W-1:0] rd2;

  // Enables are indexed by read slot; select vectors are MSB-first.
  for (genvar k = 0; k < NT; k++) begin : g_t_en
    assign en[t_slot(k)] = t_sel[NT-1-k];
  end

  for (genvar k = 0; k < NR; k++) begin : g_r_en
    assign en[r_slot(NT, k)] = r_sel[NR-1-k];
  end

  for (genvar i = 0; i < N; i++) begin : g_cell
    regfile_cell #(.W(W)) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[i]),
      .fun_sel  (fun_sel),
      .i_data   (i_data),
      .q        (q[i]),
      .d_next   (d_next[i]),
      .wrap_hit (wrap_hit[i])
    );
  end

  // Read muxes: an index matching no slot leaves the default 0.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < N; i++) begin
      if (o1_sel == SW'(i)) rd1 = (BYPASS != 0) ? d_next[i] : q[i];
      if (o2_sel == SW'(i)) rd2 = (BYPASS != 0) ? d_next[i] : q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o1   <= '0;
      o2   <= '0;
      wrap <= 1'b0;
    end else begin
      o1   <= rd1;
      o2   <= rd2;
      wrap <= |wrap_hit;
    end
  end

endmodule

// File: tb/tb_param_regfile.sv
// Bench for param_regfile. Three instances share one clock:
//   dut_a : W=8, NR=4, NT=4, BYPASS=0
//   dut_b : same configuration with BYPASS=1, same inputs as dut_a
//   dut_c : W=8, NR=3, NT=2, BYPASS=0 (out-of-range indices, own inputs)
// A behavioural model tracks R/T contents as plain integers.
module tb_param_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] i_data;
  logic [2:0] fun_sel;
  logic [3:0] r_sel, t_sel;
  logic [2:0] o1_sel, o2_sel;
  logic [7:0] a_o1, a_o2, b_o1, b_o2;
  logic       a_wrap, b_wrap;

  logic [7:0] c_data;
  logic [2:0] c_fun;
  logic [2:0] c_r_sel;
  logic [1:0] c_t_sel;
  logic [2:0] c_o1_sel, c_o2_sel;
  logic [7:0] c_o1, c_o2;
  logic       c_wrap;

  param_regfile #(.W(8), .NR(4), .NT(4), .BYPASS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .fun_sel(fun_sel),
    .r_sel(r_sel), .t_sel(t_sel), .o1_sel(o1_sel), .o2_sel(o2_sel),
    .o1(a_o1), .o2(a_o2), .wrap(a_wrap));

  param_regfile #(.W(8), .NR(4), .NT(4), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .fun_sel(fun_sel),
    .r_sel(r_sel), .t_sel(t_sel), .o1_sel(o1_sel), .o2_sel(o2_sel),
    .o1(b_o1), .o2(b_o2), .wrap(b_wrap));

  param_regfile #(.W(8), .NR(3), .NT(2), .BYPASS(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .i_data(c_data), .fun_sel(c_fun),
    .r_sel(c_r_sel), .t_sel(c_t_sel), .o1_sel(c_o1_sel), .o2_sel(c_o2_sel),
    .o1(c_o1), .o2(c_o2), .wrap(c_wrap));

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: index k holds R(k+1) / T(k+1).
  int unsigned mr[4], mt[4], sr[4], st[4];
  int unsigned ea_o1, ea_o2, eb_o1, eb_o2, ec_o1, ec_o2;
  bit          e_wrap, ec_wrap;

  function automatic int unsigned op(input logic [2:0] f, input int unsigned v,
                                     input int unsigned d);
    case (f)
      3'd0:    return 0;
      3'd1:    return d;
      3'd2:    return (v + 255) % 256;
      3'd3:    return (v + 1) % 256;
      3'd4:    return (v * 2) % 256;
      3'd5:    return v / 2;
      3'd6:    return (v * 2) % 256 + v / 128;
      default: return v;
    endcase
  endfunction

  function automatic bit wraps(input logic [2:0] f, input int unsigned v);
    return (f == 3'd3 && v == 255) || (f == 3'd2 && v == 0);
  endfunction

  function automatic int unsigned rd(input int unsigned r[4], input int unsigned t[4],
                                     input int nr, input int nt, input int idx);
    if (idx < nt) return t[idx];
    if (idx < nt + nr) return r[idx - nt];
    return 0;
  endfunction

  // Advance both models and the clock by one rising edge.
  task automatic step();
    int unsigned nr_[4], nt_[4], nsr[4], nst[4];
    for (int k = 0; k < 4; k++) begin
      nr_[k] = 0; nt_[k] = 0; nsr[k] = 0; nst[k] = 0;
    end
    if (!rst_n) begin
      ea_o1 = 0; ea_o2 = 0; eb_o1 = 0; eb_o2 = 0;
      ec_o1 = 0; ec_o2 = 0; e_wrap = 0; ec_wrap = 0;
    end else begin
      ea_o1 = rd(mr, mt, 4, 4, int'(o1_sel));
      ea_o2 = rd(mr, mt, 4, 4, int'(o2_sel));
      e_wrap = 0;
      for (int k = 0; k < 4; k++) begin
        nr_[k] = mr[k];
        nt_[k] = mt[k];
        if (r_sel[3-k]) begin
          nr_[k] = op(fun_sel, mr[k], i_data);
          e_wrap |= wraps(fun_sel, mr[k]);
        end
        if (t_sel[3-k]) begin
          nt_[k] = op(fun_sel, mt[k], i_data);
          e_wrap |= wraps(fun_sel, mt[k]);
        end
      end
      eb_o1 = rd(nr_, nt_, 4, 4, int'(o1_sel));
      eb_o2 = rd(nr_, nt_, 4, 4, int'(o2_sel));

      ec_o1 = rd(sr, st, 3, 2, int'(c_o1_sel));
      ec_o2 = rd(sr, st, 3, 2, int'(c_o2_sel));
      ec_wrap = 0;
      for (int k = 0; k < 4; k++) begin
        nsr[k] = sr[k];
        nst[k] = st[k];
      end
      for (int k = 0; k < 3; k++) begin
        if (c_r_sel[2-k]) begin
          nsr[k] = op(c_fun, sr[k], c_data);
          ec_wrap |= wraps(c_fun, sr[k]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (c_t_sel[1-k]) begin
          nst[k] = op(c_fun, st[k], c_data);
          ec_wrap |= wraps(c_fun, st[k]);
        end
      end
    end
    @(posedge clk);
    #1;
    mr = nr_; mt = nt_; sr = nsr; st = nst;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fun_sel = 3'b001; r_sel = 4'hF; t_sel = 4'hF; i_data = 8'hAA;
    c_fun = 3'b001; c_r_sel = 3'b111; c_t_sel = 2'b11; c_data = 8'hAA;
    o1_sel = 3'd4; o2_sel = 3'd0; c_o1_sel = 3'd2; c_o2_sel = 3'd4;
    step();
    step();
    n_tests++; if (a_o1 !== 8'h00) begin n_fail++; $display("FAIL reset a_o1 got=%h exp=00", a_o1); end
    n_tests++; if (a_o2 !== 8'h00) begin n_fail++; $display("FAIL reset a_o2 got=%h exp=00", a_o2); end
    n_tests++; if (a_wrap !== 1'b0) begin n_fail++; $display("FAIL reset a_wrap got=%b exp=0", a_wrap); end
    n_tests++; if (b_o1 !== 8'h00) begin n_fail++; $display("FAIL reset b_o1 got=%h exp=00", b_o1); end
    n_tests++; if (b_wrap !== 1'b0) begin n_fail++; $display("FAIL reset b_wrap got=%b exp=0", b_wrap); end
    n_tests++; if (c_o1 !== 8'h00) begin n_fail++; $display("FAIL reset c_o1 got=%h exp=00", c_o1); end
    rst_n = 1'b1; fun_sel = 3'b111; r_sel = 4'h0; t_sel = 4'h0;
    c_fun = 3'b111; c_r_sel = 3'b000; c_t_sel = 2'b00;
    for (int s = 0; s < 8; s++) begin
      o1_sel = 3'(s); o2_sel = 3'(7 - s);
      step();
      n_tests++; if (a_o1 !== 8'h00) begin n_fail++; $display("FAIL reset_sweep a_o1 sel=%0d got=%h exp=00", s, a_o1); end
      n_tests++; if (b_o2 !== 8'h00) begin n_fail++; $display("FAIL reset_sweep b_o2 sel=%0d got=%h exp=00", 7 - s, b_o2); end
    end
  endtask

  task automatic test_load_map();
    logic [7:0] exp_map [8];
    exp_map = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h11, 8'h22, 8'h33, 8'h44};
    fun_sel = 3'b001;
    for (int k = 0; k < 4; k++) begin
      r_sel = 4'b1000 >> k; t_sel = 4'b0000; i_data = 8'(8'h11 * (k + 1));
      step();
      r_sel = 4'b0000; t_sel = 4'b1000 >> k; i_data = 8'(8'h55 + 8'h11 * k);
      step();
    end
    fun_sel = 3'b111; r_sel = 4'h0; t_sel = 4'h0;
    for (int s = 0; s < 8; s++) begin
      o1_sel = 3'(s); o2_sel = 3'(s);
      step();
      n_tests++; if (a_o1 !== exp_map[s]) begin n_fail++; $display("FAIL load_map a_o1 sel=%0d got=%h exp=%h", s, a_o1, exp_map[s]); end
      n_tests++; if (a_o2 !== exp_map[s]) begin n_fail++; $display("FAIL load_map a_o2 sel=%0d got=%h exp=%h", s, a_o2, exp_map[s]); end
      n_tests++; if (b_o1 !== exp_map[s]) begin n_fail++; $display("FAIL load_map b_o1 sel=%0d got=%h exp=%h", s, b_o1, exp_map[s]); end
    end
  endtask

  task automatic test_wrap();
    r_sel = 4'b1000; t_sel = 4'b0000; o1_sel = 3'd4; fun_sel = 3'b001; i_data = 8'hFF;
    step();
    fun_sel = 3'b011;
    step();
    n_tests++; if (a_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_inc a_wrap got=%b exp=1", a_wrap); end
    n_tests++; if (a_o1 !== 8'hFF) begin n_fail++; $display("FAIL wrap_inc a_o1 got=%h exp=ff", a_o1); end
    n_tests++; if (b_o1 !== 8'h00) begin n_fail++; $display("FAIL wrap_inc b_o1 got=%h exp=00", b_o1); end
    fun_sel = 3'b111;
    step();
    n_tests++; if (a_wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_one_cycle a_wrap got=%b exp=0", a_wrap); end
    n_tests++; if (a_o1 !== 8'h00) begin n_fail++; $display("FAIL wrap_hold a_o1 got=%h exp=00", a_o1); end
    fun_sel = 3'b010;
    step();
    n_tests++; if (a_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_dec a_wrap got=%b exp=1", a_wrap); end
    n_tests++; if (b_o1 !== 8'hFF) begin n_fail++; $display("FAIL wrap_dec b_o1 got=%h exp=ff", b_o1); end
    fun_sel = 3'b011;
    step();
    n_tests++; if (b_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_inc2 b_wrap got=%b exp=1", b_wrap); end
    n_tests++; if (b_o1 !== 8'h00) begin n_fail++; $display("FAIL wrap_inc2 b_o1 got=%h exp=00", b_o1); end
    r_sel = 4'b0100; o1_sel = 3'd5; fun_sel = 3'b001; i_data = 8'h05;
    step();
    fun_sel = 3'b011;
    step();
    n_tests++; if (a_wrap !== 1'b0) begin n_fail++; $display("FAIL nowrap a_wrap got=%b exp=0", a_wrap); end
    n_tests++; if (b_o1 !== 8'h06) begin n_fail++; $display("FAIL nowrap b_o1 got=%h exp=06", b_o1); end
  endtask

  task automatic test_shift();
    logic [2:0]  ops  [3];
    logic [7:0]  exps [3];
    ops  = '{3'b100, 3'b101, 3'b110};
    exps = '{8'h02, 8'h40, 8'h03};
    r_sel = 4'b0000; t_sel = 4'b0100; o1_sel = 3'd1;
    for (int j = 0; j < 3; j++) begin
      fun_sel = 3'b001; i_data = 8'h81;
      step();
      fun_sel = ops[j];
      step();
      n_tests++; if (b_o1 !== exps[j]) begin n_fail++; $display("FAIL shift op=%0d b_o1 got=%h exp=%h", ops[j], b_o1, exps[j]); end
    end
    fun_sel = 3'b111;
    step();
    n_tests++; if (a_o1 !== 8'h03) begin n_fail++; $display("FAIL hold a_o1 got=%h exp=03", a_o1); end
    n_tests++; if (b_o1 !== 8'h03) begin n_fail++; $display("FAIL hold b_o1 got=%h exp=03", b_o1); end
    t_sel = 4'b0000; fun_sel = 3'b000;
    step();
    n_tests++; if (a_wrap !== 1'b0) begin n_fail++; $display("FAIL nosel_clr a_wrap got=%b exp=0", a_wrap); end
    for (int s = 0; s < 8; s++) begin
      o1_sel = 3'(s);
      step();
      n_tests++; if (a_o1 !== 8'(ea_o1)) begin n_fail++; $display("FAIL nosel_clr a_o1 sel=%0d got=%h exp=%h", s, a_o1, 8'(ea_o1)); end
    end
  endtask

  task automatic test_bypass();
    r_sel = 4'b0010; t_sel = 4'b0000; o1_sel = 3'd6; fun_sel = 3'b001; i_data = 8'h10;
    step();
    n_tests++; if (a_o1 !== 8'h33) begin n_fail++; $display("FAIL bypass0 old a_o1 got=%h exp=33", a_o1); end
    n_tests++; if (b_o1 !== 8'h10) begin n_fail++; $display("FAIL bypass1 new b_o1 got=%h exp=10", b_o1); end
    fun_sel = 3'b111;
    step();
    n_tests++; if (a_o1 !== 8'h10) begin n_fail++; $display("FAIL bypass0 late a_o1 got=%h exp=10", a_o1); end
    r_sel = 4'b1000; t_sel = 4'b0001; fun_sel = 3'b000;
    step();
    fun_sel = 3'b011;
    step();
    fun_sel = 3'b111; o1_sel = 3'd4; o2_sel = 3'd3;
    step();
    n_tests++; if (a_o1 !== 8'h01) begin n_fail++; $display("FAIL multi_inc R1 got=%h exp=01", a_o1); end
    n_tests++; if (a_o2 !== 8'h01) begin n_fail++; $display("FAIL multi_inc T4 got=%h exp=01", a_o2); end
  endtask

  task automatic test_small();
    fun_sel = 3'b111; r_sel = 4'h0; t_sel = 4'h0;
    c_fun = 3'b111; c_r_sel = 3'b000; c_t_sel = 2'b00;
    for (int s = 5; s < 8; s++) begin
      c_o1_sel = 3'(s); c_o2_sel = 3'(12 - s);
      step();
      n_tests++; if (c_o1 !== 8'h00) begin n_fail++; $display("FAIL out_of_range c_o1 sel=%0d got=%h exp=00", s, c_o1); end
    end
    c_o1_sel = 3'd3; c_r_sel = 3'b010; c_fun = 3'b000;
    step();
    c_fun = 3'b011;
    for (int j = 0; j < 3; j++) begin
      step();
      n_tests++; if (c_o1 !== 8'(ec_o1)) begin n_fail++; $display("FAIL count c_o1 step=%0d got=%h exp=%h", j, c_o1, 8'(ec_o1)); end
    end
    rst_n = 1'b0;
    step();
    n_tests++; if (c_o1 !== 8'h00) begin n_fail++; $display("FAIL midop_reset c_o1 got=%h exp=00", c_o1); end
    rst_n = 1'b1;
    step();
    step();
    c_fun = 3'b111;
    step();
    n_tests++; if (c_o1 !== 8'h02) begin n_fail++; $display("FAIL resume c_o1 got=%h exp=02", c_o1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 39) != 0);
      fun_sel  = 3'($urandom); r_sel = 4'($urandom); t_sel = 4'($urandom);
      i_data   = 8'($urandom); o1_sel = 3'($urandom); o2_sel = 3'($urandom);
      c_fun    = 3'($urandom); c_r_sel = 3'($urandom); c_t_sel = 2'($urandom);
      c_data   = 8'($urandom); c_o1_sel = 3'($urandom); c_o2_sel = 3'($urandom);
      // Bias towards inc/dec at the boundaries so wrap is exercised.
      if ($urandom_range(0, 3) == 0) i_data = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      step();
      n_tests++; if (a_o1 !== 8'(ea_o1)) begin n_fail++; $display("FAIL random a_o1 cyc=%0d got=%h exp=%h", i, a_o1, 8'(ea_o1)); end
      n_tests++; if (a_o2 !== 8'(ea_o2)) begin n_fail++; $display("FAIL random a_o2 cyc=%0d got=%h exp=%h", i, a_o2, 8'(ea_o2)); end
      n_tests++; if (b_o1 !== 8'(eb_o1)) begin n_fail++; $display("FAIL random b_o1 cyc=%0d got=%h exp=%h", i, b_o1, 8'(eb_o1)); end
      n_tests++; if (b_o2 !== 8'(eb_o2)) begin n_fail++; $display("FAIL random b_o2 cyc=%0d got=%h exp=%h", i, b_o2, 8'(eb_o2)); end
      n_tests++; if (a_wrap !== e_wrap) begin n_fail++; $display("FAIL random a_wrap cyc=%0d got=%b exp=%b", i, a_wrap, e_wrap); end
      n_tests++; if (b_wrap !== e_wrap) begin n_fail++; $display("FAIL random b_wrap cyc=%0d got=%b exp=%b", i, b_wrap, e_wrap); end
      n_tests++; if (c_o1 !== 8'(ec_o1)) begin n_fail++; $display("FAIL random c_o1 cyc=%0d got=%h exp=%h", i, c_o1, 8'(ec_o1)); end
      n_tests++; if (c_o2 !== 8'(ec_o2)) begin n_fail++; $display("FAIL random c_o2 cyc=%0d got=%h exp=%h", i, c_o2, 8'(ec_o2)); end
      n_tests++; if (c_wrap !== ec_wrap) begin n_fail++; $display("FAIL random c_wrap cyc=%0d got=%b exp=%b", i, c_wrap, ec_wrap); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      mr[k] = 0; mt[k] = 0; sr[k] = 0; st[k] = 0;
    end
    rst_n = 1'b0; i_data = '0; fun_sel = 3'b111; r_sel = '0; t_sel = '0;
    o1_sel = '0; o2_sel = '0;
    c_data = '0; c_fun = 3'b111; c_r_sel = '0; c_t_sel = '0;
    c_o1_sel = '0; c_o2_sel = '0;
    @(negedge clk);
    test_reset();
    test_load_map();
    test_wrap();
    test_shift();
    test_bypass();
    test_small();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
